// File: rtl/superscalar_processor.sv
// 2-way in-order superscalar core, 5-stage IF/ID/EX/MEM/WB pipeline.
// Unified word-addressed memory; RAW hazards resolved by ID stalls.
package ssp_pkg;
    localparam logic [5:0] OP_ADD = 6'o00, OP_SUB = 6'o01, OP_MUL = 6'o02;
    localparam logic [5:0] OP_AND = 6'o03, OP_OR = 6'o04, OP_XOR = 6'o05;
    localparam logic [5:0] OP_SLL = 6'o06, OP_SRL = 6'o07;
    localparam logic [5:0] OP_ADDI = 6'o10, OP_SUBI = 6'o11, OP_ANDI = 6'o12;
    localparam logic [5:0] OP_ORI = 6'o13, OP_XORI = 6'o14;
    localparam logic [5:0] OP_LW = 6'o20, OP_SW = 6'o21;
    localparam logic [5:0] OP_BEQ = 6'o30, OP_BNE = 6'o31;
    localparam logic [5:0] OP_BLT = 6'o32, OP_BGE = 6'o33;
    localparam logic [5:0] OP_J = 6'o40, OP_JAL = 6'o41;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
    } if_id_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic        v;
        logic        ld;
        logic        st;
        logic [4:0]  dst;
        logic [31:0] res;
        logic [31:0] sd;
    } ex_mem_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  dst;
        logic [31:0] val;
    } mem_wb_t;

    function automatic logic is_r(input logic [5:0] op);
        return op <= OP_SRL;
    endfunction

    function automatic logic is_i(input logic [5:0] op);
        return op >= OP_ADDI && op <= OP_XORI;
    endfunction

    function automatic logic is_br(input logic [5:0] op);
        return op >= OP_BEQ && op <= OP_BGE;
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return op == OP_LW || op == OP_SW;
    endfunction

    function automatic logic is_ctl(input logic [5:0] op);
        return is_br(op) || op == OP_J || op == OP_JAL;
    endfunction

    function automatic logic uses_rs(input logic [5:0] op);
        return is_r(op) || is_i(op) || is_mem(op) || is_br(op);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return is_r(op) || op == OP_SW || is_br(op);
    endfunction

    function automatic logic [4:0] dst_of(input logic [5:0] op,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        unique case (1'b1)
            is_r(op):                  d = rd;
            is_i(op) || op == OP_LW:   d = rt;
            op == OP_JAL:              d = 5'd31;
            default:                   d = 5'd0;
        endcase
        return d;
    endfunction
endpackage

module superscalar_processor
    import ssp_pkg::*;
#(
    parameter int MEM_DEPTH = 1028,
    parameter int REG_COUNT = 32
) (
    input  logic        clk1,
    input  logic        reset,
    output logic [31:0] dbg_pc
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] MEM [MEM_DEPTH];
    logic [31:0] REG [REG_COUNT];

    logic [31:0] pc;
    if_id_t  [1:0] ifd;
    id_ex_t  [1:0] ie;
    ex_mem_t [1:0] em;
    mem_wb_t [1:0] mw;

    logic [31:0] f0, f1;
    logic [4:0]  d0;
    logic        split, stall, take;
    logic [31:0] tgt;
    id_ex_t  [1:0] dec;
    ex_mem_t [1:0] exr;
    mem_wb_t [1:0] mwn;

    assign dbg_pc = pc;

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return (a < MEM_DEPTH) ? MEM[a[AW-1:0]] : 32'd0;
    endfunction

    // write-first read: a WB commit this cycle is seen by ID
    function automatic logic [31:0] rf(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (mw[1].v && mw[1].dst == r) return mw[1].val;
        if (mw[0].v && mw[0].dst == r) return mw[0].val;
        return REG[r];
    endfunction

    function automatic logic pend(input logic [4:0] r);
        logic p;
        p = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (ie[k].v && ie[k].dst == r) p = 1'b1;
            if (em[k].v && em[k].dst == r) p = 1'b1;
        end
        return p && r != 5'd0;
    endfunction

    // fetch the pair and decide whether slot1 must wait a cycle
    always_comb begin
        f0 = mrd(pc);
        f1 = mrd(pc + 32'd1);
        d0 = dst_of(f0[31:26], f0[20:16], f0[15:11]);
        split = is_ctl(f0[31:26])
             || (is_mem(f0[31:26]) && is_mem(f1[31:26]))
             || (d0 != 5'd0 &&
                 ((uses_rs(f1[31:26]) && f1[25:21] == d0)
               || (uses_rt(f1[31:26]) && f1[20:16] == d0)
               || dst_of(f1[31:26], f1[20:16], f1[15:11]) == d0));
    end

    // decode, register read and RAW stall detection
    always_comb begin
        stall = 1'b0;
        dec = '0;
        for (int s = 0; s < 2; s++) begin
            dec[s].v   = ifd[s].v;
            dec[s].pc  = ifd[s].pc;
            dec[s].op  = ifd[s].ins[31:26];
            dec[s].dst = dst_of(ifd[s].ins[31:26], ifd[s].ins[20:16],
                                ifd[s].ins[15:11]);
            dec[s].a   = rf(ifd[s].ins[25:21]);
            dec[s].b   = rf(ifd[s].ins[20:16]);
            if (dec[s].op == OP_ANDI || dec[s].op == OP_ORI
                || dec[s].op == OP_XORI)
                dec[s].imm = {16'd0, ifd[s].ins[15:0]};
            else if (dec[s].op == OP_J || dec[s].op == OP_JAL)
                dec[s].imm = {6'd0, ifd[s].ins[25:0]};
            else
                dec[s].imm = {{16{ifd[s].ins[15]}}, ifd[s].ins[15:0]};
            if (ifd[s].v && uses_rs(dec[s].op) && pend(ifd[s].ins[25:21]))
                stall = 1'b1;
            if (ifd[s].v && uses_rt(dec[s].op) && pend(ifd[s].ins[20:16]))
                stall = 1'b1;
        end
    end

    // execute both slots and resolve control flow
    always_comb begin
        take = 1'b0;
        tgt = 32'd0;
        exr = '0;
        for (int s = 0; s < 2; s++) begin
            logic [31:0] r;
            logic        t;
            r = 32'd0;
            t = 1'b0;
            case (ie[s].op)
                OP_ADD:  r = ie[s].a + ie[s].b;
                OP_SUB:  r = ie[s].a - ie[s].b;
                OP_MUL:  r = ie[s].a * ie[s].b;
                OP_AND:  r = ie[s].a & ie[s].b;
                OP_OR:   r = ie[s].a | ie[s].b;
                OP_XOR:  r = ie[s].a ^ ie[s].b;
                OP_SLL:  r = ie[s].a << ie[s].b[4:0];
                OP_SRL:  r = ie[s].a >> ie[s].b[4:0];
                OP_ADDI, OP_LW, OP_SW: r = ie[s].a + ie[s].imm;
                OP_SUBI: r = ie[s].a - ie[s].imm;
                OP_ANDI: r = ie[s].a & ie[s].imm;
                OP_ORI:  r = ie[s].a | ie[s].imm;
                OP_XORI: r = ie[s].a ^ ie[s].imm;
                OP_BEQ:  t = ie[s].a == ie[s].b;
                OP_BNE:  t = ie[s].a != ie[s].b;
                OP_BLT:  t = $signed(ie[s].a) < $signed(ie[s].b);
                OP_BGE:  t = $signed(ie[s].a) >= $signed(ie[s].b);
                OP_J:    t = 1'b1;
                OP_JAL: begin
                    t = 1'b1;
                    r = ie[s].pc + 32'd1;
                end
                default: r = 32'd0;
            endcase
            exr[s].v   = ie[s].v;
            exr[s].ld  = ie[s].v && ie[s].op == OP_LW;
            exr[s].st  = ie[s].v && ie[s].op == OP_SW;
            exr[s].dst = ie[s].v ? ie[s].dst : 5'd0;
            exr[s].res = r;
            exr[s].sd  = ie[s].b;
            if (ie[s].v && t) begin
                take = 1'b1;
                tgt = (ie[s].op == OP_J || ie[s].op == OP_JAL)
                    ? ie[s].imm : ie[s].pc + 32'd1 + ie[s].imm;
            end
        end
    end

    // memory-stage load data into the WB bundle
    always_comb begin
        for (int s = 0; s < 2; s++)
            mwn[s] = {em[s].v, em[s].dst,
                      em[s].ld ? mrd(em[s].res) : em[s].res};
    end

    // pipeline registers and PC
    always_ff @(posedge clk1) begin
        if (reset) begin
            pc  <= 32'd0;
            ifd <= '0;
            ie  <= '0;
            em  <= '0;
            mw  <= '0;
        end else begin
            em <= exr;
            mw <= mwn;
            if (take) begin
                pc  <= tgt;
                ifd <= '0;
                ie  <= '0;
            end else if (stall) begin
                ie <= '0;
            end else begin
                pc     <= pc + (split ? 32'd1 : 32'd2);
                ifd[0] <= {1'b1, pc, f0};
                ifd[1] <= {~split, pc + 32'd1, f1};
                ie     <= dec;
            end
        end
    end

    // stores commit in MEM; out-of-range addresses are dropped
    always_ff @(posedge clk1) begin
        if (!reset)
            for (int s = 0; s < 2; s++)
                if (em[s].st && em[s].res < MEM_DEPTH)
                    MEM[em[s].res[AW-1:0]] <= em[s].sd;
    end

    // WB commits slot0 then slot1; R0 is never written
    always_ff @(posedge clk1) begin
        if (!reset)
            for (int s = 0; s < 2; s++)
                if (mw[s].v && mw[s].dst != 5'd0)
                    REG[mw[s].dst] <= mw[s].val;
    end
endmodule

// File: tb/tb_superscalar_processor.sv
// Directed programs for superscalar_processor; expected architectural
// state is queued when each program is loaded and checked after it runs.
module tb_superscalar_processor;
    logic        clk1 = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dbg_pc;

    superscalar_processor dut (
        .clk1   (clk1),
        .reset  (reset),
        .dbg_pc (dbg_pc)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int nvec = 0;
    int nerr = 0;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    function automatic logic [31:0] rr(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] jj(input logic [5:0] op,
        input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic setup();
        reset = 1'b1;
        tick(1);
        for (int i = 0; i < 1028; i++) dut.MEM[i] = NOP;
        for (int i = 0; i < 32; i++) dut.REG[i] = 32'd0;
    endtask

    task automatic go();
        tick(1);
        reset = 1'b0;
    endtask

    task automatic want(input string tag, input int kind, input int idx,
                        input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.kind = kind;
        e.idx = idx;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = dut.REG[e.idx];
                1:       obs = dut.MEM[e.idx];
                default: obs = dbg_pc;
            endcase
            nvec++;
            assert (obs === e.exp) else begin
                nerr++;
                $error("FAIL %s: observed %0h expected %0h",
                       e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        // load/store program
        setup();
        dut.MEM[1]  = ii(6'o20, 0, 1, 16'd50);
        dut.MEM[2]  = ii(6'o20, 0, 3, 16'd80);
        dut.MEM[4]  = ii(6'o20, 0, 2, 16'd40);
        dut.MEM[6]  = ii(6'o21, 0, 1, 16'd15);
        dut.MEM[9]  = ii(6'o21, 0, 2, 16'd16);
        dut.MEM[10] = ii(6'o21, 0, 3, 16'd17);
        dut.MEM[50] = 32'd100;
        dut.MEM[40] = 32'd200;
        dut.MEM[80] = 32'd300;
        want("ls_r1", 0, 1, 32'd100);
        want("ls_r2", 0, 2, 32'd200);
        want("ls_r3", 0, 3, 32'd300);
        want("ls_m15", 1, 15, 32'd100);
        want("ls_m16", 1, 16, 32'd200);
        want("ls_m17", 1, 17, 32'd300);
        go();
        tick(20);
        drain();

        // dual issue, then an intra-pair dependency that splits
        setup();
        dut.MEM[0] = ii(6'o10, 0, 1, 16'd5);
        dut.MEM[1] = ii(6'o10, 0, 2, 16'd7);
        dut.MEM[2] = rr(6'o00, 1, 2, 3);
        dut.MEM[3] = rr(6'o01, 3, 1, 4);
        go();
        tick(1);
        want("pair_pc2", 2, 0, 32'd2);
        drain();
        tick(1);
        want("split_pc3", 2, 0, 32'd3);
        drain();
        tick(15);
        want("alu_r1", 0, 1, 32'd5);
        want("alu_r2", 0, 2, 32'd7);
        want("alu_r3", 0, 3, 32'd12);
        want("alu_r4", 0, 4, 32'd7);
        drain();

        // load-use stall until the load reaches WB
        setup();
        dut.MEM[0]  = ii(6'o20, 0, 5, 16'd40);
        dut.MEM[1]  = rr(6'o00, 5, 5, 6);
        dut.MEM[40] = 32'd200;
        go();
        tick(3);
        want("raw_hold_pc", 2, 0, 32'd3);
        drain();
        tick(2);
        want("raw_go_pc", 2, 0, 32'd5);
        drain();
        tick(10);
        want("raw_r5", 0, 5, 32'd200);
        want("raw_r6", 0, 6, 32'd400);
        drain();

        // taken BEQ skips 1-3, untaken BNE falls through
        setup();
        dut.MEM[0] = ii(6'o30, 0, 0, 16'd3);
        dut.MEM[1] = ii(6'o10, 0, 7, 16'd1);
        dut.MEM[2] = ii(6'o10, 0, 8, 16'd1);
        dut.MEM[3] = ii(6'o10, 0, 9, 16'd1);
        dut.MEM[4] = ii(6'o31, 0, 0, 16'd5);
        dut.MEM[5] = ii(6'o10, 0, 10, 16'd11);
        dut.MEM[6] = ii(6'o10, 0, 11, 16'd22);
        want("beq_r7", 0, 7, 32'd0);
        want("beq_r8", 0, 8, 32'd0);
        want("beq_r9", 0, 9, 32'd0);
        want("bne_r10", 0, 10, 32'd11);
        want("bne_r11", 0, 11, 32'd22);
        go();
        tick(20);
        drain();

        // JAL links, redirects and squashes the following pair
        setup();
        dut.MEM[8]  = jj(6'o41, 26'd20);
        dut.MEM[9]  = ii(6'o10, 0, 13, 16'd1);
        dut.MEM[10] = ii(6'o10, 0, 14, 16'd1);
        dut.MEM[20] = ii(6'o10, 0, 15, 16'd3);
        want("jal_r31", 0, 31, 32'd9);
        want("jal_r13", 0, 13, 32'd0);
        want("jal_r14", 0, 14, 32'd0);
        want("jal_r15", 0, 15, 32'd3);
        go();
        tick(25);
        drain();

        // R0 immutable, out-of-range load, reset mid-run
        setup();
        dut.REG[18] = 32'd55;
        dut.MEM[0]  = ii(6'o10, 0, 0, 16'd9);
        dut.MEM[6]  = ii(6'o10, 0, 16, 16'd4);
        dut.MEM[8]  = ii(6'o20, 0, 18, 16'd1030);
        go();
        tick(10);
        want("r0_zero", 0, 0, 32'd0);
        want("r0_use_r16", 0, 16, 32'd4);
        want("oob_lw_r18", 0, 18, 32'd0);
        want("run_pc20", 2, 0, 32'd20);
        drain();
        reset = 1'b1;
        tick(1);
        want("rst_pc0", 2, 0, 32'd0);
        drain();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
